// File: rtl/montgomery_reduce_pipe.sv
// -----------------------------------------------------------------------------
// montgomery_reduce_pipe
//   Multi-lane, 3-stage pipelined modular reducer for the Kyber datapath
//   (q = 3329). Each beat carries LANES signed 32-bit operands. Every lane of
//   the beat is reduced either by Montgomery reduction (a * 2^-16 mod q) or
//   by Barrett reduction, selected by `mode`. The mode and the frame marker
//   travel through the pipe alongside the data.
//
// Ports
//   clk        clock
//   reset      synchronous, active-high reset (takes priority over set)
//   set        global enable; 0 freezes every pipeline register
//   in_valid   input beat valid
//   in_ready   input beat accepted when in_valid && in_ready
//   mode       0 = Montgomery, 1 = Barrett (applies to all lanes of the beat)
//   in_last    frame marker, passed through with the beat
//   a          lane i = a[32*i +: 32], signed
//   out_valid  output beat valid
//   out_ready  downstream accept
//   out_last   in_last of the beat currently presented on t
//   t          lane i = t[16*i +: 16], signed
// -----------------------------------------------------------------------------
module montgomery_reduce_pipe #(
   parameter int LANES = 2,
   parameter int Q     = 3329,
   parameter int QINV  = -3327,
   parameter int BV    = 20159
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  set,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic                  mode,
   input  logic                  in_last,
   input  logic [32*LANES-1:0]   a,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  out_last,
   output logic [16*LANES-1:0]   t
);

   // All arithmetic is done modulo 2^32; the low 32 bits of a product or sum
   // do not depend on signedness, so only the arithmetic shift needs $signed.
   localparam logic [31:0] Q_W    = 32'(Q);
   localparam logic [31:0] QINV_W = 32'(QINV);
   localparam logic [31:0] BV_W   = 32'(BV);
   localparam logic [31:0] ROUND  = 32'h0200_0000;   // 2^25, Barrett rounding

   // Stage 1: Montgomery -> u = low16(a) * QINV (sign-extended 16-bit)
   //          Barrett    -> m = BV * x + 2^25, x = sign-extended low16(a)
   function automatic logic [31:0] stage1(input logic [31:0] a_in, input logic md);
      logic [31:0] x;
      logic [31:0] u;
      logic [31:0] m;
      x = {{16{a_in[15]}}, a_in[15:0]};
      u = x * QINV_W;
      m = x * BV_W + ROUND;
      return md ? m : {{16{u[15]}}, u[15:0]};
   endfunction

   // Stage 2: Montgomery -> p = u * Q
   //          Barrett    -> k = m >>> 26
   function automatic logic [31:0] stage2(input logic [31:0] r, input logic md);
      logic [31:0] u;
      logic [31:0] p;
      logic [31:0] k;
      u = {{16{r[15]}}, r[15:0]};
      p = u * Q_W;
      k = $signed(r) >>> 26;
      return md ? k : p;
   endfunction

   // Stage 3: Montgomery -> (a - p) >>> 16; the low half of a - p is zero,
   //          so the upper half is the result.
   //          Barrett    -> x - k*Q; only 16 result bits are kept, so the
   //          subtraction is done on the low halves only.
   function automatic logic [15:0] stage3(input logic [31:0] a_in, input logic [31:0] r,
                                          input logic md);
      logic [31:0] diff;
      logic [31:0] kq;
      diff = a_in - r;
      kq   = r * Q_W;
      return md ? (a_in[15:0] - kq[15:0]) : diff[31:16];
   endfunction

   logic adv;

   logic        s1_valid, s1_mode, s1_last;
   logic        s2_valid, s2_mode, s2_last;

   logic [31:0] a_s1 [LANES];
   logic [31:0] r1   [LANES];
   logic [31:0] a_s2 [LANES];
   logic [31:0] r2   [LANES];

   logic [16*LANES-1:0] t_next;

   // The whole pipe moves as one; a full pipe may accept and emit in the same
   // cycle. in_ready never looks at in_valid.
   assign adv      = set && (!out_valid || out_ready);
   assign in_ready = adv;

   // NOTE: every variable assigned in always_comb gets a default first so no
   // path through the block leaves it unassigned (which would infer a latch).
   always_comb begin
      t_next = '0;
      for (int i = 0; i < LANES; i++) begin
         t_next[16*i +: 16] = stage3(a_s2[i], r2[i], s2_mode);
      end
   end

   // NOTE: the operand/intermediate registers have no reset. They are only
   // meaningful when the matching stage valid is set, and the valids are reset.
   always_ff @(posedge clk) begin
      if (adv) begin
         for (int i = 0; i < LANES; i++) begin
            a_s1[i] <= a[32*i +: 32];
            r1[i]   <= stage1(a[32*i +: 32], mode);
            a_s2[i] <= a_s1[i];
            r2[i]   <= stage2(r1[i], s1_mode);
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples its pre-edge inputs and stage order inside the block is irrelevant.
   always_ff @(posedge clk) begin
      if (reset) begin
         s1_valid  <= 1'b0;
         s1_mode   <= 1'b0;
         s1_last   <= 1'b0;
         s2_valid  <= 1'b0;
         s2_mode   <= 1'b0;
         s2_last   <= 1'b0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         t         <= '0;
      end else if (adv) begin
         s1_valid  <= in_valid;
         s1_mode   <= mode;
         s1_last   <= in_valid && in_last;   // bubbles never carry a marker
         s2_valid  <= s1_valid;
         s2_mode   <= s1_mode;
         s2_last   <= s1_last;
         out_valid <= s2_valid;
         out_last  <= s2_last;
         t         <= t_next;
      end
   end

endmodule
